// File: rtl/dff_reg.sv
// dff_reg: parameterizable D register / STAGES-deep delay line with enable, sync clear and valid side-band
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset (s = RESET_VAL, v = 0)
//   en    - shift enable
//   clr   - synchronous clear, overrides en
//   d     - data in (WIDTH bits)
//   vld_i - valid flag accompanying d
//   q     - last data stage
//   vld_o - last valid stage
module dff_reg #(
    parameter int              WIDTH     = 1,
    parameter int              STAGES    = 1,
    parameter logic [1023:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             vld_i,
    output logic [WIDTH-1:0] q,
    output logic             vld_o
);
    localparam logic [WIDTH-1:0] RV = RESET_VAL[WIDTH-1:0];

    generate
        if (STAGES < 1) begin : g_bad_stages
            $fatal(1, "dff_reg: STAGES must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] s [STAGES];
    logic [STAGES-1:0] v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            for (int i = 0; i < STAGES; i++) s[i] <= RV;
            v <= '0;
        end else if (en) begin
            s[0] <= d;
            v[0] <= vld_i;
            for (int i = 1; i < STAGES; i++) begin
                s[i] <= s[i-1];
                v[i] <= v[i-1];
            end
        end
    end

    assign q     = s[STAGES-1];
    assign vld_o = v[STAGES-1];
endmodule

// File: tb/tb_dff_reg.sv
// tb_dff_reg: directed self-checking bench for dff_reg in 1x1, 32x4 and 32x4 (reset value A5) configurations
module tb_dff_reg;
    logic        clk = 1'b0;
    logic        rst, en, clr, vld_i;
    logic [31:0] d32;
    logic        q1, v1;
    logic [31:0] q32, qa5;
    logic        v32, va5;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dff_reg u1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .d(d32[0]), .vld_i(vld_i), .q(q1), .vld_o(v1)
    );

    dff_reg #(.WIDTH(32), .STAGES(4), .RESET_VAL(0)) u32 (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .d(d32), .vld_i(vld_i), .q(q32), .vld_o(v32)
    );

    dff_reg #(.WIDTH(32), .STAGES(4), .RESET_VAL(32'hA5)) ua5 (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .d(d32), .vld_i(vld_i), .q(qa5), .vld_o(va5)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] pat;
        rst = 1'b0; en = 1'b1; clr = 1'b0; d32 = '0; vld_i = 1'b0;
        // async reset between edges
        #2 rst = 1'b1;
        #1;
        chk("rst_q1", {31'b0, q1}, 32'h0);
        chk("rst_v1", {31'b0, v1}, 32'h0);
        chk("rst_q32", q32, 32'h0);
        chk("rst_qa5", qa5, 32'hA5);
        chk("rst_va5", {31'b0, va5}, 32'h0);
        // edge while held in reset is ignored
        d32 = 32'h1; vld_i = 1'b1;
        tick;
        chk("rst_hold_q1", {31'b0, q1}, 32'h0);
        chk("rst_hold_v1", {31'b0, v1}, 32'h0);
        rst = 1'b0;
        tick;
        chk("rel_q1", {31'b0, q1}, 32'h1);
        chk("rel_v1", {31'b0, v1}, 32'h1);
        // plain DFF toggle 1,0,1,1,0
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            d32 = {31'b0, pat[i]};
            tick;
            chk("dff_toggle", {31'b0, q1}, {31'b0, pat[i]});
        end
        // flush pipelines with invalid zeros
        d32 = '0; vld_i = 1'b0;
        repeat (4) tick;
        chk("flush_v32", {31'b0, v32}, 32'h0);
        // pipeline latency of 4
        d32 = 32'h12345678; vld_i = 1'b1;
        tick;
        d32 = '0; vld_i = 1'b0;
        chk("lat_e1_v", {31'b0, v32}, 32'h0);
        tick;
        chk("lat_e2_v", {31'b0, v32}, 32'h0);
        tick;
        chk("lat_e3_v", {31'b0, v32}, 32'h0);
        tick;
        chk("lat_e4_q", q32, 32'h12345678);
        chk("lat_e4_v", {31'b0, v32}, 32'h1);
        tick;
        chk("lat_e5_q", q32, 32'h0);
        chk("lat_e5_v", {31'b0, v32}, 32'h0);
        repeat (3) tick;
        // enable stall of 3 edges mid-flight
        d32 = 32'hCAFEF00D; vld_i = 1'b1;
        tick;
        d32 = '0; vld_i = 1'b0;
        tick;
        en = 1'b0;
        repeat (3) begin
            tick;
            chk("stall_v", {31'b0, v32}, 32'h0);
        end
        en = 1'b1;
        tick;
        chk("stall_e3_v", {31'b0, v32}, 32'h0);
        tick;
        chk("stall_q", q32, 32'hCAFEF00D);
        chk("stall_v_out", {31'b0, v32}, 32'h1);
        // clear priority over enable
        vld_i = 1'b1;
        d32 = 32'h11; tick;
        d32 = 32'h22; tick;
        d32 = 32'h33; tick;
        d32 = 32'h44; tick;
        chk("full_qa5", qa5, 32'h11);
        chk("full_va5", {31'b0, va5}, 32'h1);
        clr = 1'b1; d32 = 32'hDEADBEEF;
        tick;
        chk("clr_qa5", qa5, 32'hA5);
        chk("clr_va5", {31'b0, va5}, 32'h0);
        chk("clr_q32", q32, 32'h0);
        clr = 1'b0; d32 = '0; vld_i = 1'b0;
        repeat (3) begin
            tick;
            chk("clr_no_d_q", qa5, 32'hA5);
            chk("clr_no_d_v", {31'b0, va5}, 32'h0);
        end
        tick;
        chk("clr_shift_q", qa5, 32'h0);
        // async reset with three valid samples in flight
        vld_i = 1'b1;
        d32 = 32'h1; tick;
        d32 = 32'h2; tick;
        d32 = 32'h3; tick;
        d32 = '0; vld_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_q32", q32, 32'h0);
        chk("mid_rst_v32", {31'b0, v32}, 32'h0);
        chk("mid_rst_qa5", qa5, 32'hA5);
        chk("mid_rst_va5", {31'b0, va5}, 32'h0);
        rst = 1'b0;
        repeat (4) begin
            tick;
            chk("post_rst_v32", {31'b0, v32}, 32'h0);
            chk("post_rst_va5", {31'b0, va5}, 32'h0);
        end
        chk("post_rst_q32", q32, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dff_reg.md
Name: dff_reg

Overview:
- Parameterizable D-type register/delay line; base storage cell of the design.
- Default configuration (WIDTH=1, STAGES=1, en tied high, clr tied low) behaves as a plain 1-bit D flip-flop: q follows d one clock later.
- Deeper configurations form a STAGES-deep shift pipeline with enable, synchronous clear and a valid side-band, used to retime or delay datapath signals.

Parameters:
- WIDTH, 1, data width in bits of d and q; legal range 1..1024.
- STAGES, 1, number of register stages between d and q; legal range 1..64. Elaborating with 0 is a fatal error.
- RESET_VAL, 0, value loaded into every data stage on reset or clear; truncated or zero-extended to WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous and active-high.
- en  input  1  shift enable; tie to 1 for free-running flip-flop behaviour.
- clr  input  1  synchronous clear, active-high.
- d  input  WIDTH  data in.
- vld_i  input  1  valid flag accompanying d.
- q  output  WIDTH  data out = last stage.
- vld_o  output  1  valid flag of last stage.

Behaviour:
- State:
  - data stages s[0..STAGES-1], each WIDTH bits;
  - valid stages v[0..STAGES-1], each 1 bit.
- Reset:
  - rst=1 forces all s[i]=RESET_VAL and all v[i]=0 immediately, without waiting for a clock edge.
  - State holds while rst=1; clk edges are ignored.
  - Outputs after reset: q=RESET_VAL, vld_o=0.
- Reset release: the first rising edge with rst=0 operates normally. No synchronizer is inside this block.
- Rising edge with rst=0, priority clr > en > hold:
  - clr=1: all s[i]<=RESET_VAL, all v[i]<=0, regardless of en.
  - clr=0, en=1: s[0]<=d, v[0]<=vld_i; s[i]<=s[i-1], v[i]<=v[i-1] for i>=1.
  - clr=0, en=0: all stages hold.
- Outputs: q=s[STAGES-1], vld_o=v[STAGES-1]. Purely registered, with no combinational path from any input to q or vld_o.
- Latency: a sample enters on an enabled edge and appears on q after exactly STAGES enabled edges. Disabled edges stretch the delay but lose no data.
- STAGES=1: q equals the d captured at the previous enabled edge (classic DFF).
- Reset mid-operation: rst asserted at any phase discards all in-flight data and valid bits; no partial shift occurs.
- Simultaneous events:
  - rst asserted coincident with a clk edge: reset wins.
  - clr=1 and en=1 on the same edge: clear wins; d is not captured.
- X handling: d is transferred bit-exact with no masking. vld_i=X propagates as X.
- Width: no arithmetic. RESET_VAL wider than WIDTH uses its low WIDTH bits.

Test Plan:
- Reset: WIDTH=1, STAGES=1, en=1, clr=0. Assert rst=1 mid-cycle (no clk edge) -> q=0 and vld_o=0 immediately. Deassert rst, d=1 -> q=1 after the next rising edge.
- Plain DFF toggle: WIDTH=1, STAGES=1, drive d = 1,0,1,1,0 on successive edges -> q = 1,0,1,1,0, each one cycle later.
- Pipeline latency: WIDTH=32, STAGES=4, RESET_VAL=0. Send d=32'h12345678 with vld_i=1 for one cycle, then vld_i=0 -> q=32'h12345678 and vld_o=1 exactly 4 edges later, for one cycle only.
- Enable stall: same setup, en=0 for 3 edges mid-flight -> the sample emerges after 4+3 edges with its value intact.
- Clear priority: STAGES=4, RESET_VAL=32'hA5, pipeline full of valid data. Apply clr=1 and en=1 for one edge -> q=32'hA5 and vld_o=0 on the next edge. The d presented at that edge never appears on q.
- Async reset mid-stream: STAGES=4, three valid samples in flight. Pulse rst=1 between edges -> q=RESET_VAL and vld_o=0 at once; no sample appears on q afterwards.
